// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - clocked main-memory responder with programmable wait states and ready handshake
module mem_wait_responder #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic              write,
    input  logic              load,
    input  logic              store,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("mem_wait_responder: RD_LAT must be within 1..15");
    end
    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
        $error("mem_wait_responder: WR_LAT must be within 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE,
        HOLD
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] cap_addr, cap_addr_nx;
    logic [DATA_W-1:0] cap_data, cap_data_nx;
    logic              ready_nx, busy_nx, err_nx;
    logic              rd_done, wr_done;
    logic              rd_req, wr_req, req;

    // read/write without load/store belong to the register file, not to us
    assign rd_req = read & load;
    assign wr_req = write & store;
    assign req    = rd_req | wr_req;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cap_addr_nx = cap_addr;
        cap_data_nx = cap_data;
        ready_nx    = ready;
        busy_nx     = busy;
        err_nx      = err;
        rd_done     = 1'b0;
        wr_done     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cap_addr_nx = address;
                    cap_data_nx = data_in;
                    busy_nx     = 1'b1;
                    if (wr_req) begin
                        // a simultaneous read is dropped and flagged
                        cnt_nx   = WR_LOAD;
                        state_nx = WR_WAIT;
                        if (rd_req) err_nx = 1'b1;
                    end else begin
                        cnt_nx   = RD_LOAD;
                        state_nx = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    rd_done  = 1'b1;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WR_WAIT: begin
                if (cnt == 4'd0) begin
                    wr_done  = 1'b1;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                ready_nx = 1'b0;
                state_nx = HOLD;
            end
            HOLD: begin
                // a level request is serviced once; it must drop before re-arming
                if (!req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cap_addr <= '0;
            cap_data <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cap_addr <= cap_addr_nx;
            cap_data <= cap_data_nx;
            ready    <= ready_nx;
            busy     <= busy_nx;
            err      <= err_nx;
            if (rd_done) data_out <= mem[cap_addr];
        end
    end

    // RAM contents survive reset; reset only cancels the pending commit via state
    always_ff @(posedge clk) begin
        if (wr_done) mem[cap_addr] <= cap_data;
    end

endmodule
